// File: rtl/scan_pkg.sv
// Shared move-code vocabulary and FSM state type for the scan move streamer.
package scan_pkg;

    localparam int MOVE_W = 4;

    localparam logic [MOVE_W-1:0] MV_NOP = 4'd0;
    localparam logic [MOVE_W-1:0] MV_R   = 4'd2;
    localparam logic [MOVE_W-1:0] MV_RI  = 4'd3;
    localparam logic [MOVE_W-1:0] MV_U   = 4'd4;
    localparam logic [MOVE_W-1:0] MV_UI  = 4'd5;
    localparam logic [MOVE_W-1:0] MV_F   = 4'd6;
    localparam logic [MOVE_W-1:0] MV_FI  = 4'd7;
    localparam logic [MOVE_W-1:0] MV_L   = 4'd8;
    localparam logic [MOVE_W-1:0] MV_LI  = 4'd9;
    localparam logic [MOVE_W-1:0] MV_B   = 4'd10;
    localparam logic [MOVE_W-1:0] MV_BI  = 4'd11;
    localparam logic [MOVE_W-1:0] MV_D   = 4'd12;
    localparam logic [MOVE_W-1:0] MV_DI  = 4'd13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/scan_move_rom.sv
// Per-step move table with a registered (1-cycle) read; first move sits in slot 0.
module scan_move_rom
    import scan_pkg::*;
#(
    parameter int MOVE_W    = scan_pkg::MOVE_W,
    parameter int MAX_MOVES = 24,
    parameter int NUM_STEPS = 49,
    localparam int STEP_W   = $clog2(NUM_STEPS),
    localparam int LEN_W    = $clog2(MAX_MOVES+1)
) (
    input  logic                        clock,
    input  logic [STEP_W-1:0]           step_addr,
    output logic [LEN_W-1:0]            length,
    output logic [MAX_MOVES*MOVE_W-1:0] moves
);

    logic [LEN_W-1:0]                  tbl_len;
    logic [MAX_MOVES-1:0][MOVE_W-1:0]  tbl_moves;

    always_comb begin
        // Filler steps cycle through the twelve face turns R..Di.
        tbl_len = LEN_W'((int'(step_addr) % 5) + 1);
        for (int i = 0; i < MAX_MOVES; i++)
            tbl_moves[i] = MOVE_W'(int'(MV_R) + ((int'(step_addr) + 3*i) % 12));
        case (step_addr)
            STEP_W'(0): begin
                tbl_len      = LEN_W'(5);
                tbl_moves    = '0;
                tbl_moves[0] = MV_L;
                tbl_moves[1] = MV_RI;
                tbl_moves[2] = MV_FI;
                tbl_moves[3] = MV_U;
                tbl_moves[4] = MV_UI;
            end
            STEP_W'(1): begin
                tbl_len      = LEN_W'(3);
                tbl_moves    = '0;
                tbl_moves[0] = MV_F;
                tbl_moves[1] = MV_R;
                tbl_moves[2] = MV_RI;
            end
            STEP_W'(2): begin
                tbl_len   = '0;
                tbl_moves = '0;
            end
            // Deliberately over-long entry; the streamer clamps it.
            STEP_W'(3): tbl_len = '1;
            STEP_W'(NUM_STEPS-1): begin
                tbl_len      = LEN_W'(6);
                tbl_moves    = '0;
                tbl_moves[0] = MV_L;
                tbl_moves[1] = MV_RI;
                tbl_moves[2] = MV_FI;
                tbl_moves[3] = MV_D;
                tbl_moves[4] = MV_L;
                tbl_moves[5] = MV_RI;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        length <= tbl_len;
        moves  <= tbl_moves;
    end

endmodule

// File: rtl/scan_move_streamer.sv
// Steps through the scan sequence, streaming each step's move batch over a valid/ready port.
module scan_move_streamer
    import scan_pkg::*;
#(
    parameter int MOVE_W    = scan_pkg::MOVE_W,
    parameter int MAX_MOVES = 24,
    parameter int NUM_STEPS = 49,
    localparam int STEP_W   = $clog2(NUM_STEPS),
    localparam int LEN_W    = $clog2(MAX_MOVES+1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              next_step,
    input  logic              restart,
    input  logic              move_ready,
    output logic [MOVE_W-1:0] move,
    output logic              move_valid,
    output logic              last_move,
    output logic [STEP_W-1:0] step,
    output logic              busy,
    output logic              batch_done,
    output logic              seq_done
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS-1);
    localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_MOVES);

    state_t                            state;
    logic [LEN_W-1:0]                  rom_len, len_c, len, idx;
    logic [MAX_MOVES*MOVE_W-1:0]       rom_moves;
    logic [MAX_MOVES-1:0][MOVE_W-1:0]  slots;

    // ROM re-reads the current step every cycle, so its output is ready during LOAD
    // and stays put for the whole batch because step only moves in FINISH.
    scan_move_rom #(
        .MOVE_W    (MOVE_W),
        .MAX_MOVES (MAX_MOVES),
        .NUM_STEPS (NUM_STEPS)
    ) u_rom (
        .clock     (clock),
        .step_addr (step),
        .length    (rom_len),
        .moves     (rom_moves)
    );

    assign slots = rom_moves;
    assign len_c = (rom_len > MAX_LEN) ? MAX_LEN : rom_len;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            step       <= '0;
            move       <= '0;
            move_valid <= 1'b0;
            last_move  <= 1'b0;
            busy       <= 1'b0;
            batch_done <= 1'b0;
            seq_done   <= 1'b0;
            len        <= '0;
            idx        <= '0;
        end else begin
            batch_done <= 1'b0;
            if (restart) begin
                state      <= IDLE;
                step       <= '0;
                seq_done   <= 1'b0;
                move       <= '0;
                move_valid <= 1'b0;
                last_move  <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (next_step && !seq_done) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                    LOAD: begin
                        len <= len_c;
                        if (len_c == '0) begin
                            state      <= FINISH;
                            batch_done <= 1'b1;
                        end else begin
                            state      <= STREAM;
                            move       <= slots[0];
                            move_valid <= 1'b1;
                            last_move  <= (len_c == LEN_W'(1));
                            idx        <= LEN_W'(1);
                        end
                    end
                    STREAM: if (move_ready) begin
                        if (last_move) begin
                            state      <= FINISH;
                            batch_done <= 1'b1;
                            move       <= '0;
                            move_valid <= 1'b0;
                            last_move  <= 1'b0;
                        end else begin
                            move      <= slots[idx];
                            last_move <= (idx == len - LEN_W'(1));
                            idx       <= idx + LEN_W'(1);
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (step == LAST_STEP) seq_done <= 1'b1;
                        else                   step     <= step + STEP_W'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_move_streamer.sv
// Randomized bench for scan_move_streamer against a table-level model of the step sequence.
module tb_scan_move_streamer;

    localparam int MOVE_W    = 4;
    localparam int MAX_MOVES = 24;
    localparam int NUM_STEPS = 49;
    localparam int STEP_W    = $clog2(NUM_STEPS);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              next_step = 1'b0;
    logic              restart = 1'b0;
    logic              move_ready = 1'b0;
    logic [MOVE_W-1:0] move;
    logic              move_valid, last_move, busy, batch_done, seq_done;
    logic [STEP_W-1:0] step;

    int n_chk = 0;
    int n_fail = 0;
    int model_step = 0;
    int model_seq = 0;

    scan_move_streamer #(
        .MOVE_W    (MOVE_W),
        .MAX_MOVES (MAX_MOVES),
        .NUM_STEPS (NUM_STEPS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .next_step  (next_step),
        .restart    (restart),
        .move_ready (move_ready),
        .move       (move),
        .move_valid (move_valid),
        .last_move  (last_move),
        .step       (step),
        .busy       (busy),
        .batch_done (batch_done),
        .seq_done   (seq_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (step %0d, t=%0t)", tag, got, exp, model_step, $time);
        end
    endtask

    // Stored length per step; step 3 holds an all-ones (31) entry.
    function automatic int model_len_raw(input int s);
        if (s == 0) return 5;
        if (s == 1) return 3;
        if (s == 2) return 0;
        if (s == 3) return 31;
        if (s == NUM_STEPS-1) return 6;
        return (s % 5) + 1;
    endfunction

    function automatic int model_len(input int s);
        int l = model_len_raw(s);
        return (l > MAX_MOVES) ? MAX_MOVES : l;
    endfunction

    function automatic int model_move(input int s, input int i);
        int t0[5]  = '{8, 3, 7, 4, 5};
        int t1[3]  = '{6, 2, 3};
        int t48[6] = '{8, 3, 7, 12, 8, 3};
        if (i < 0 || i >= model_len(s)) return 99;
        if (s == 0) return t0[i];
        if (s == 1) return t1[i];
        if (s == NUM_STEPS-1) return t48[i];
        return 2 + ((s + 3*i) % 12);
    endfunction

    function automatic void model_advance();
        if (model_step == NUM_STEPS-1) model_seq = 1;
        else model_step++;
    endfunction

    // Issue one next_step and consume the batch; hold_n stalls the first valid cycles,
    // poke throws extra next_step pulses while busy.
    task automatic do_batch(input int rdy_pct, input int hold_n, input bit poke);
        int len, k, c, held;
        bit done;
        len = model_len(model_step);
        @(negedge clock); next_step = 1'b1; move_ready = 1'b0;
        @(negedge clock); next_step = 1'b0;
        chk("load_valid", move_valid, 0);
        chk("load_busy", busy, 1);
        k = 0; c = 1; held = 0; done = 0;
        while (!done && c < 300) begin
            @(negedge clock); c++;
            if (c == 2) chk("first_valid", move_valid, len > 0);
            if (batch_done) begin
                done = 1;
                chk("batch_len", k, len);
                chk("done_no_valid", move_valid, 0);
                if (rdy_pct == 100 && hold_n == 0) chk("done_cycle", c, len + 2);
                next_step = 1'b0; move_ready = 1'b0;
            end else begin
                if (move_valid) begin
                    chk("move", move, model_move(model_step, k));
                    chk("last_move", last_move, k == len - 1);
                    if (held < hold_n) begin move_ready = 1'b0; held++; end
                    else move_ready = ($urandom_range(99) < rdy_pct);
                    if (move_ready) k++;
                end else begin
                    chk("nop_move", move, 0);
                    move_ready = 1'($urandom_range(1));
                end
                next_step = poke ? 1'($urandom_range(1)) : 1'b0;
            end
        end
        if (!done) chk("batch_timeout", 0, 1);
        @(negedge clock);
        model_advance();
        chk("step", step, model_step);
        chk("seq_done", seq_done, model_seq);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_move", move, 0);
        chk("rst_valid", move_valid, 0);
        chk("rst_last", last_move, 0);
        chk("rst_step", step, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bdone", batch_done, 0);
        chk("rst_seq", seq_done, 0);
        reset = 1'b0;
        @(negedge clock);

        do_batch(100, 0, 0);            // step 0, back-to-back
        do_batch(100, 4, 1);            // step 1, 4-cycle stall, ignored pulses
        for (int s = 2; s < NUM_STEPS; s++) do_batch(60, 0, 1);
        chk("seq_end_done", seq_done, 1);
        chk("seq_end_step", step, NUM_STEPS-1);

        @(negedge clock); next_step = 1'b1;
        @(negedge clock); next_step = 1'b0;
        repeat (4) begin
            @(negedge clock);
            chk("after_seq_valid", move_valid, 0);
            chk("after_seq_busy", busy, 0);
        end
        chk("after_seq_step", step, NUM_STEPS-1);

        @(negedge clock); restart = 1'b1;
        @(negedge clock); restart = 1'b0;
        model_step = 0; model_seq = 0;
        chk("restart_step", step, 0);
        chk("restart_seq", seq_done, 0);

        // Restart on the second transfer of step 0.
        @(negedge clock); next_step = 1'b1;
        @(negedge clock); next_step = 1'b0; move_ready = 1'b1;
        @(negedge clock); chk("rs_first", move, 8);
        @(negedge clock); chk("rs_second", move, 3); restart = 1'b1;
        @(negedge clock); restart = 1'b0; move_ready = 1'b0;
        chk("rs_valid", move_valid, 0);
        chk("rs_busy", busy, 0);
        chk("rs_step", step, 0);
        repeat (4) begin
            @(negedge clock);
            chk("rs_no_bdone", batch_done, 0);
            chk("rs_no_valid", move_valid, 0);
        end
        do_batch(100, 0, 0);            // re-emits step 0

        // restart and next_step together: restart wins.
        @(negedge clock); next_step = 1'b1; restart = 1'b1;
        @(negedge clock); next_step = 1'b0; restart = 1'b0;
        model_step = 0;
        repeat (3) begin
            @(negedge clock);
            chk("both_valid", move_valid, 0);
            chk("both_busy", busy, 0);
        end
        chk("both_step", step, 0);

        // Asynchronous reset in the middle of step 1's stream.
        do_batch(70, 0, 1);
        @(negedge clock); next_step = 1'b1; move_ready = 1'b0;
        @(negedge clock); next_step = 1'b0;
        @(negedge clock); chk("ar_streaming", move_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", move_valid, 0);
        chk("ar_move", move, 0);
        chk("ar_last", last_move, 0);
        chk("ar_step", step, 0);
        chk("ar_seq", seq_done, 0);
        chk("ar_busy", busy, 0);
        @(negedge clock); reset = 1'b0; move_ready = 1'b1;
        model_step = 0; model_seq = 0;
        repeat (3) begin
            @(negedge clock);
            chk("ar_no_resume", move_valid, 0);
        end
        do_batch(70, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
